seg7_bus_decoder: RTL and testbench

- Monitors a multiplexed 7-segment display bus (anode enables plus shared segment lines) and recovers the hex nibble shown on each digit. It is the receive-side inverse of the team's hex-to-segment encoder.
- Used for display loopback self-test and for the logic-analyser readback path.
- Synchronizes the asynchronous bus, qualifies stable one-hot frames and decodes segment patterns.
- Holds per-digit value, valid and error registers.

---
 rtl/seg7_pkg.sv | 73 +++++++
 rtl/seg7_bus_decoder_if.sv | 13 +
 rtl/seg7_stability_filter.sv | 109 ++++++++++
 rtl/seg7_bus_decoder.sv | 101 ++++++++++
 tb/tb_seg7_bus_decoder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern constants (common with the encoder),
// filter state encoding and the pattern-to-nibble decode. SEG7_DP_EN adds the decimal-point bit.
package seg7_pkg;

`ifdef SEG7_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] SEG7_0     = 7'b0000001;
    localparam logic [6:0] SEG7_1     = 7'b1001111;
    localparam logic [6:0] SEG7_2     = 7'b0010010;
    localparam logic [6:0] SEG7_3     = 7'b0000110;
    localparam logic [6:0] SEG7_4     = 7'b1001100;
    localparam logic [6:0] SEG7_5     = 7'b0100100;
    localparam logic [6:0] SEG7_6     = 7'b0100000;
    localparam logic [6:0] SEG7_7     = 7'b0001111;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0000100;
    localparam logic [6:0] SEG7_A     = 7'b0001000;
    localparam logic [6:0] SEG7_B     = 7'b1100000;
    localparam logic [6:0] SEG7_C     = 7'b0110001;
    localparam logic [6:0] SEG7_D     = 7'b1000010;
    localparam logic [6:0] SEG7_E     = 7'b0110000;
    localparam logic [6:0] SEG7_F     = 7'b0111000;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } filt_state_t;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg7_dec_t;

    function automatic seg7_dec_t seg7_to_hex(input logic [6:0] seg);
        seg7_dec_t d;
        d.legal  = 1'b1;
        d.blank  = 1'b0;
        d.nibble = 4'h0;
        case (seg)
            SEG7_0:     d.nibble = 4'h0;
            SEG7_1:     d.nibble = 4'h1;
            SEG7_2:     d.nibble = 4'h2;
            SEG7_3:     d.nibble = 4'h3;
            SEG7_4:     d.nibble = 4'h4;
            SEG7_5:     d.nibble = 4'h5;
            SEG7_6:     d.nibble = 4'h6;
            SEG7_7:     d.nibble = 4'h7;
            SEG7_8:     d.nibble = 4'h8;
            SEG7_9:     d.nibble = 4'h9;
            SEG7_A:     d.nibble = 4'hA;
            SEG7_B:     d.nibble = 4'hB;
            SEG7_C:     d.nibble = 4'hC;
            SEG7_D:     d.nibble = 4'hD;
            SEG7_E:     d.nibble = 4'hE;
            SEG7_F:     d.nibble = 4'hF;
            SEG7_BLANK: begin
                d.legal = 1'b0;
                d.blank = 1'b1;
            end
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_bus_decoder_if.sv
// Multiplexed display bus: anode enables plus shared segment lines.
// Segment width follows SEG7_DP_EN through the package.
interface seg7_bus_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;

    modport master (output an, output seg);
    modport slave  (input an, input seg);
endinterface

// File: rtl/seg7_stability_filter.sv
// Synchronizes the display bus and qualifies stable one-hot frames; emits a
// single-cycle capture strobe with the digit index and segment pattern.
module seg7_stability_filter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int AN_ACTIVE_LOW = 1,
    localparam int IDX_W        = $clog2(NUM_DIGITS),
    localparam int CNT_W        = $clog2(STABLE_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] an,
    input  logic [SEG_W-1:0]      seg,
    output logic                  cap_o,
    output logic [IDX_W-1:0]      cap_idx_o,
    output logic [SEG_W-1:0]      cap_seg_o
);

    localparam int CAND_W = NUM_DIGITS + SEG_W;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

    logic [NUM_DIGITS-1:0] an_s1_reg, an_s2_reg;
    logic [SEG_W-1:0]      seg_s1_reg, seg_s2_reg;
    logic [CAND_W-1:0]     cand_prev_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    filt_state_t           state_reg, state_next;

    logic [CAND_W-1:0]     cand;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  onehot;
    logic                  same;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s1_reg     <= AN_IDLE;
            an_s2_reg     <= AN_IDLE;
            seg_s1_reg    <= {SEG_W{1'b1}};
            seg_s2_reg    <= {SEG_W{1'b1}};
            cand_prev_reg <= {AN_IDLE, {SEG_W{1'b1}}};
            count_reg     <= '0;
            state_reg     <= ST_IDLE;
        end else begin
            an_s1_reg     <= an;
            an_s2_reg     <= an_s1_reg;
            seg_s1_reg    <= seg;
            seg_s2_reg    <= seg_s1_reg;
            cand_prev_reg <= cand;
            count_reg     <= count_next;
            state_reg     <= state_next;
        end
    end

    assign cand   = {an_s2_reg, seg_s2_reg};
    assign an_n   = (AN_ACTIVE_LOW != 0) ? ~an_s2_reg : an_s2_reg;
    assign onehot = $onehot(an_n);
    assign same   = (cand == cand_prev_reg);

    always_comb begin
        cap_idx_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_n[i]) cap_idx_o = IDX_W'(i);
        end
    end
    assign cap_seg_o = seg_s2_reg;

    // Capture fires on the edge that registers the last of STABLE_CYCLES identical samples
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        cap_o      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (onehot) begin
                    state_next = ST_SETTLE;
                    count_next = '0;
                end
            end
            ST_SETTLE: begin
                if (!onehot) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (!same) begin
                    count_next = '0;
                end else if (count_reg == CNT_LAST) begin
                    cap_o      = 1'b1;
                    state_next = ST_LOCKED;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!same) begin
                    state_next = onehot ? ST_SETTLE : ST_IDLE;
                    count_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_bus_decoder.sv
// Recovers the hex nibble shown on each digit of a multiplexed 7-segment bus.
// SEG7_DP_EN widens seg with a decimal point and adds dp_o.
module seg7_bus_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int AN_ACTIVE_LOW = 1,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_bus_decoder_if.slave       bus,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   valid_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    upd_o,
    output logic [IDX_W-1:0]        upd_idx_o
`ifdef SEG7_DP_EN
    ,
    output logic [NUM_DIGITS-1:0]   dp_o
`endif
);

    logic             cap;
    logic [IDX_W-1:0] cap_idx;
    logic [SEG_W-1:0] cap_seg;
    seg7_dec_t        dec;
    logic             upd_reg;
    logic [IDX_W-1:0] upd_idx_reg;

    seg7_stability_filter #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .AN_ACTIVE_LOW (AN_ACTIVE_LOW)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .an        (bus.an),
        .seg       (bus.seg),
        .cap_o     (cap),
        .cap_idx_o (cap_idx),
        .cap_seg_o (cap_seg)
    );

    // The decimal point never influences decode
    assign dec = seg7_to_hex(cap_seg[6:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_reg     <= 1'b0;
            upd_idx_reg <= '0;
        end else begin
            upd_reg <= cap;
            if (cap) upd_idx_reg <= cap_idx;
        end
    end

    assign upd_o     = upd_reg;
    assign upd_idx_o = upd_idx_reg;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic       hit;
        logic [3:0] nib_reg;
        logic       valid_reg;
        logic       err_reg;

        assign hit = cap && (cap_idx == IDX_W'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                nib_reg   <= 4'h0;
                valid_reg <= 1'b0;
                err_reg   <= 1'b0;
            end else if (hit) begin
                if (dec.legal) begin
                    nib_reg   <= dec.nibble;
                    valid_reg <= 1'b1;
                    err_reg   <= 1'b0;
                end else begin
                    valid_reg <= 1'b0;
                    err_reg   <= !dec.blank;
                end
            end
        end

        assign digits_o[4*gi +: 4] = nib_reg;
        assign valid_o[gi]         = valid_reg;
        assign err_o[gi]           = err_reg;

`ifdef SEG7_DP_EN
        logic dp_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      dp_reg <= 1'b0;
            else if (hit) dp_reg <= ~cap_seg[7];
        end
        assign dp_o[gi] = dp_reg;
`endif
    end

endmodule

// File: tb/tb_seg7_bus_decoder.sv
// Scoreboarded bench for seg7_bus_decoder (4 digits, 8 stable cycles, active-low anodes).
module tb_seg7_bus_decoder;
    import seg7_pkg::*;

    localparam int ND = 4;
    localparam int SC = 8;

    typedef struct {
        int         idx;
        logic [6:0] pat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_o;
    logic [3:0]  valid_o;
    logic [3:0]  err_o;
    logic        upd_o;
    logic [1:0]  upd_idx_o;
`ifdef SEG7_DP_EN
    logic [3:0]  dp_o;
`endif

    seg7_bus_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg7_bus_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .digits_o  (digits_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .upd_o     (upd_o),
        .upd_idx_o (upd_idx_o)
`ifdef SEG7_DP_EN
        ,
        .dp_o      (dp_o)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          upd_count = 0;
    int          last_upd_cyc = -1;
    int          drive_cyc = 0;
    logic [15:0] mdl_dig = '0;
    logic [3:0]  mdl_val = '0;
    logic [3:0]  mdl_err = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every upd_o pulse retires one scoreboard entry and checks the whole register file
    always @(negedge clk) begin
        if (!rst && upd_o) begin
            exp_t e;
            logic legal;
            logic [3:0] nib;
            upd_count++;
            last_upd_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_upd idx=%0d digits=%h", upd_idx_o, digits_o);
            end else begin
                e = sb_q.pop_front();
                legal = 1'b0;
                nib = 4'h0;
                for (int n = 0; n < 16; n++) begin
                    if (hex_tab[n] == e.pat) begin
                        legal = 1'b1;
                        nib = n[3:0];
                    end
                end
                if (legal) begin
                    mdl_dig[e.idx*4 +: 4] = nib;
                    mdl_val[e.idx] = 1'b1;
                    mdl_err[e.idx] = 1'b0;
                end else begin
                    mdl_val[e.idx] = 1'b0;
                    mdl_err[e.idx] = (e.pat != 7'h7F);
                end
                checks++;
                if (upd_idx_o !== e.idx[1:0]) begin
                    errors++;
                    $display("FAIL upd_idx got=%0d exp=%0d", upd_idx_o, e.idx);
                end
                checks++;
                if (digits_o !== mdl_dig) begin
                    errors++;
                    $display("FAIL digits got=%h exp=%h", digits_o, mdl_dig);
                end
                checks++;
                if (valid_o !== mdl_val) begin
                    errors++;
                    $display("FAIL valid got=%b exp=%b", valid_o, mdl_val);
                end
                checks++;
                if (err_o !== mdl_err) begin
                    errors++;
                    $display("FAIL err got=%b exp=%b", err_o, mdl_err);
                end
                $display("upd idx=%0d pat=%b digits=%h valid=%b err=%b",
                         upd_idx_o, e.pat, digits_o, valid_o, err_o);
            end
        end
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] pat);
        @(posedge clk);
        #2;
        bus.an = an;
`ifdef SEG7_DP_EN
        bus.seg = {1'b1, pat};
`else
        bus.seg = pat;
`endif
        drive_cyc = cyc;
    endtask

    task automatic apply(input logic [3:0] an, input logic [6:0] pat,
                         input int cycles, input int exp_idx);
        exp_t e;
        drive(an, pat);
        if (exp_idx >= 0) begin
            e.idx = exp_idx;
            e.pat = pat;
            sb_q.push_back(e);
        end
        repeat (cycles - 1) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d exp=0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.an = 4'hF;
        bus.seg = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({digits_o, valid_o, err_o, upd_o, upd_idx_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%b/%b/%0d exp=0",
                     digits_o, valid_o, err_o, upd_o, upd_idx_o);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int u0 = upd_count;
        apply(4'b1110, 7'b0010010, 12, 0);
        wait_drain("basic");
        checks++;
        if (upd_count - u0 != 1) begin
            errors++;
            $display("FAIL basic_upd_count got=%0d exp=1", upd_count - u0);
        end
        checks++;
        if (last_upd_cyc - drive_cyc != SC + 2) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", last_upd_cyc - drive_cyc, SC + 2);
        end
        checks++;
        if (digits_o[3:0] !== 4'h2 || valid_o !== 4'b0001 || err_o !== 4'b0000) begin
            errors++;
            $display("FAIL basic_regs got=%h/%b/%b exp=2/0001/0000", digits_o[3:0], valid_o, err_o);
        end
    endtask

    task automatic test_glitch();
        int u0 = upd_count;
        apply(4'b1101, 7'b0001000, 5, -1);
        apply(4'b1101, 7'b0110001, 10, 1);
        wait_drain("glitch");
        checks++;
        if (upd_count - u0 != 1 || digits_o[7:4] !== 4'hC) begin
            errors++;
            $display("FAIL glitch got=%0d/%h exp=1/c", upd_count - u0, digits_o[7:4]);
        end
    endtask

    task automatic test_illegal();
        apply(4'b1011, 7'b0001111, 10, 2);
        apply(4'b1011, 7'b1111110, 10, 2);
        wait_drain("illegal");
        checks++;
        if (err_o[2] !== 1'b1 || valid_o[2] !== 1'b0 || digits_o[11:8] !== 4'h7) begin
            errors++;
            $display("FAIL illegal got=%b/%b/%h exp=1/0/7", err_o[2], valid_o[2], digits_o[11:8]);
        end
    endtask

    task automatic test_blank_multi();
        int u0 = upd_count;
        apply(4'b0111, 7'h7F, 10, 3);
        wait_drain("blank");
        checks++;
        if (upd_count - u0 != 1 || valid_o[3] !== 1'b0 || err_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL blank got=%0d/%b/%b exp=1/0/0", upd_count - u0, valid_o[3], err_o[3]);
        end
        u0 = upd_count;
        apply(4'b1100, 7'b0000000, 20, -1);
        checks++;
        if (upd_count != u0) begin
            errors++;
            $display("FAIL multi_anode_upd got=%0d exp=0", upd_count - u0);
        end
    endtask

    task automatic test_round_robin();
        int u0 = upd_count;
        for (int c = 0; c < 16; c++) begin
            logic [3:0] an;
            an = ~(4'b0001 << (c % 4));
            apply(an, hex_tab[c], 10, c % 4);
        end
        wait_drain("rr");
        checks++;
        if (upd_count - u0 != 16) begin
            errors++;
            $display("FAIL rr_upd_count got=%0d exp=16", upd_count - u0);
        end
        checks++;
        if (digits_o !== 16'hFEDC || valid_o !== 4'hF || err_o !== 4'h0) begin
            errors++;
            $display("FAIL rr_final got=%h/%b/%b exp=fedc/1111/0000", digits_o, valid_o, err_o);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int rel;
        apply(4'b1101, 7'b0100100, 5, -1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        mdl_dig = '0;
        mdl_val = '0;
        mdl_err = '0;
        checks++;
        if ({digits_o, valid_o, err_o, upd_o} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h/%b/%b/%b exp=0", digits_o, valid_o, err_o, upd_o);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rel = cyc;
        e.idx = 1;
        e.pat = 7'b0100100;
        sb_q.push_back(e);
        wait_drain("midrst");
        checks++;
        if (last_upd_cyc - rel != SC + 2) begin
            errors++;
            $display("FAIL midrst_latency got=%0d exp=%0d", last_upd_cyc - rel, SC + 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_illegal();
        test_blank_multi();
        test_round_robin();
        test_reset_mid();
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
